spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 12 +
 rtl/spi_slave_sync_edge.sv | 33 +++
 rtl/spi_slave.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave and its master counterpart:
// FSM state encodings and the default frame width.
package spi_slave_pkg;

    localparam int SPI_DEFAULT_N = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus single-cycle rise/fall
// pulses taken from stage 2 against a stage-3 history register.
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Reset value matches the idle line level so reset release creates no edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
            s3_q <= RESET_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled by clk_i. One-deep TX buffer is
// loaded into the shift register at frame start and at every back-to-back frame.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int n = SPI_DEFAULT_N
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sclk_i,
    input  logic         cs_n_i,
    input  logic         mosi_i,
    output logic         miso_o,
    input  logic [n-1:0] tx_data_i,
    input  logic         tx_we_i,
    output logic         tx_ready_o,
    output logic [n-1:0] rx_data_o,
    output logic         rx_valid_o,
    output logic         busy_o
);

    localparam int CNT_W = (n > 1) ? $clog2(n) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(n - 1);

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (sclk_i),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (cs_n_i),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    logic mosi_s1_q;
    logic mosi_s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            mosi_s1_q <= mosi_i;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    spi_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [n-1:0]     shift_q;
    logic [n-2:0]     rx_shift_q;
    logic [n-1:0]     rx_data_q;
    logic             rx_valid_q;
    logic [n-1:0]     tx_buf_q;
    logic             tx_full_q;
    logic             frame_done_q;

    logic [n-1:0] rx_word_d;
    logic [n-1:0] load_word_d;

    assign rx_word_d   = {rx_shift_q, mosi_s2_q};
    assign load_word_d = tx_full_q ? tx_buf_q : '0;

    // A reload clears tx_full_q after the write path so an accepted write
    // (only possible when the buffer was empty) survives for the next frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_buf_q     <= '0;
            tx_full_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (tx_we_i && !tx_full_q) begin
                tx_buf_q  <= tx_data_i;
                tx_full_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_q      <= ST_SHIFT;
                        shift_q      <= load_word_d;
                        rx_shift_q   <= '0;
                        cnt_q        <= '0;
                        frame_done_q <= 1'b0;
                        if (tx_full_q) tx_full_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        state_q      <= ST_IDLE;
                        shift_q      <= '0;
                        rx_shift_q   <= '0;
                        cnt_q        <= '0;
                        frame_done_q <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift_q <= rx_word_d[n-2:0];
                        if (cnt_q == CNT_LAST) begin
                            cnt_q        <= '0;
                            rx_data_q    <= rx_word_d;
                            rx_valid_q   <= 1'b1;
                            frame_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (sclk_fall) begin
                        if (frame_done_q) begin
                            shift_q      <= load_word_d;
                            frame_done_q <= 1'b0;
                            if (tx_full_q) tx_full_q <= 1'b0;
                        end else begin
                            shift_q <= shift_q << 1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // shift_q is cleared whenever the FSM leaves SHIFT, so miso idles low.
    assign miso_o     = shift_q[n-1];
    assign busy_o     = (state_q == ST_SHIFT);
    assign tx_ready_o = ~tx_full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;

endmodule
